// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands and control from ID,
// with stall hold, flush-to-bubble and a WB refresh of held operands.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_reg #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALU_OP_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_read_data_1,
   input  logic [XLEN-1:0]       id_read_data_2,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic                  id_alu_src,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_reg_write,
   input  logic                  id_mem_to_reg,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_read_data_1,
   output logic [XLEN-1:0]       ex_read_data_2,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  ex_alu_src,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic                  ex_mem_to_reg,
   output logic [31:0]           bubble_cnt,
   output logic [31:0]           stall_cnt
);

   localparam int unsigned CNT_W = 32;

   logic refresh_1;
   logic refresh_2;

   // WB refresh match: the retiring write targets a held source register (never x0)
   always_comb begin
      refresh_1 = 1'b0;
      refresh_2 = 1'b0;
      if (wb_reg_write && (wb_rd != REG_ADDR_W'(0))) begin
         refresh_1 = (wb_rd == ex_rs1);
         refresh_2 = (wb_rd == ex_rs2);
      end
   end

   // Pipeline register: rst > flush > stall (hold + refresh) > load
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid       <= 1'b0;
         ex_pc          <= '0;
         ex_read_data_1 <= '0;
         ex_read_data_2 <= '0;
         ex_imm         <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         ex_alu_op      <= '0;
         ex_alu_src     <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
      end else if (stall) begin
         if (refresh_1) ex_read_data_1 <= wb_data;
         if (refresh_2) ex_read_data_2 <= wb_data;
      end else begin
         ex_valid       <= id_valid;
         ex_pc          <= id_pc;
         ex_read_data_1 <= id_read_data_1;
         ex_read_data_2 <= id_read_data_2;
         ex_imm         <= id_imm;
         ex_rs1         <= id_rs1;
         ex_rs2         <= id_rs2;
         ex_rd          <= id_rd;
         ex_alu_op      <= id_alu_op;
         ex_alu_src     <= id_alu_src;
         ex_mem_read    <= id_mem_read;
         ex_mem_write   <= id_mem_write;
         ex_reg_write   <= id_reg_write;
         ex_mem_to_reg  <= id_mem_to_reg;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   // Bubble and stall counters, wrapping, cleared by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else if (flush) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (stall) begin
         stall_cnt  <= stall_cnt + CNT_W'(1);
      end
   end
`else
   // Counters disabled: tie off
   assign bubble_cnt = CNT_W'(0);
   assign stall_cnt  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus a randomized run
// against a rule-level reference model of the EX-stage slot.
module tb_id_ex_reg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
   } slot_t;

`ifdef ID_EX_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   slot_t       drv;

   logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
   logic [31:0] ex_pc, ex_read_data_1, ex_read_data_2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_alu_op;
   logic [31:0] bubble_cnt, stall_cnt;
   slot_t       got;

   // Reference model state
   slot_t       mdl;
   logic [31:0] mdl_bub, mdl_stl;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(drv.valid), .id_pc(drv.pc),
      .id_read_data_1(drv.rd1), .id_read_data_2(drv.rd2), .id_imm(drv.imm),
      .id_rs1(drv.rs1), .id_rs2(drv.rs2), .id_rd(drv.rd),
      .id_alu_op(drv.alu_op), .id_alu_src(drv.alu_src),
      .id_mem_read(drv.mem_read), .id_mem_write(drv.mem_write),
      .id_reg_write(drv.reg_write), .id_mem_to_reg(drv.mem_to_reg),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   always_comb got = {ex_valid, ex_pc, ex_read_data_1, ex_read_data_2, ex_imm,
                      ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src,
                      ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg};

   function automatic slot_t rand_slot();
      slot_t s;
      s.valid      = 1'($urandom);
      s.pc         = $urandom;
      s.rd1        = $urandom;
      s.rd2        = $urandom;
      s.imm        = $urandom;
      s.rs1        = 5'($urandom_range(0, 7));
      s.rs2        = 5'($urandom_range(0, 7));
      s.rd         = 5'($urandom);
      s.alu_op     = 4'($urandom);
      s.alu_src    = 1'($urandom);
      s.mem_read   = 1'($urandom);
      s.mem_write  = 1'($urandom);
      s.reg_write  = 1'($urandom);
      s.mem_to_reg = 1'($urandom);
      return s;
   endfunction

   // Apply inputs, advance the model by the slot rules, then step one clock
   task automatic cycle(input logic r, input logic s, input logic f, input slot_t d,
                        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
      rst = r; stall = s; flush = f; drv = d;
      wb_reg_write = wbw; wb_rd = wbr; wb_data = wbd;
      if (r) begin
         mdl = '0; mdl_bub = 0; mdl_stl = 0;
      end else if (f) begin
         mdl = '0; mdl_bub = mdl_bub + 1;
      end else if (s) begin
         mdl_stl = mdl_stl + 1;
         if (wbw && wbr != 0 && wbr == mdl.rs1) mdl.rd1 = wbd;
         if (wbw && wbr != 0 && wbr == mdl.rs2) mdl.rd2 = wbd;
      end else begin
         mdl = d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      slot_t ones = '1;
      for (int i = 0; i < 2; i++) begin
         cycle(1, 0, 0, ones, 0, 0, 0);
         n_cmp++;
         if (got !== slot_t'(0)) begin
            n_bad++; $display("FAIL reset_slot[%0d]: got %h want 0", i, got);
         end
         n_cmp++;
         if (bubble_cnt !== 0 || stall_cnt !== 0) begin
            n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", bubble_cnt, stall_cnt);
         end
      end
      cycle(0, 0, 0, ones, 0, 0, 0);
      n_cmp++;
      if (got !== ones) begin
         n_bad++; $display("FAIL reset_release: got %h want %h", got, ones);
      end
   endtask

   task automatic test_pass_through();
      slot_t d = '0;
      d.pc = 32'h100; d.rd1 = 32'hDEADBEEF; d.rd = 5'd7; d.reg_write = 1'b1; d.valid = 1'b1;
      cycle(0, 0, 0, d, 0, 0, 0);
      n_cmp++;
      if (ex_pc !== 32'h100 || ex_read_data_1 !== 32'hDEADBEEF || ex_rd !== 5'd7 ||
          ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
         n_bad++; $display("FAIL pass_through: got %h want %h", got, d);
      end
   endtask

   task automatic test_stall_hold();
      slot_t d = rand_slot();
      slot_t held;
      d.rs1 = 5'd3; d.valid = 1'b1;
      cycle(0, 0, 0, d, 0, 0, 0);
      held = d;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, rand_slot(), 0, 5'd3, $urandom);
         n_cmp++;
         if (got !== held) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, got, held);
         end
      end
      d = rand_slot();
      cycle(0, 0, 0, d, 0, 0, 0);
      n_cmp++;
      if (got !== d) begin
         n_bad++; $display("FAIL stall_release: got %h want %h", got, d);
      end
   endtask

   task automatic test_wb_refresh();
      slot_t d = rand_slot();
      slot_t want;
      d.rs1 = 5'd5; d.rs2 = 5'd5;
      cycle(0, 0, 0, d, 0, 0, 0);
      cycle(0, 1, 0, rand_slot(), 1, 5'd5, 32'h12345678);
      n_cmp++;
      if (ex_read_data_1 !== 32'h12345678 || ex_read_data_2 !== 32'h12345678) begin
         n_bad++; $display("FAIL wb_refresh: got %h/%h want 12345678/12345678",
                           ex_read_data_1, ex_read_data_2);
      end
      want = d; want.rd1 = 32'h12345678; want.rd2 = 32'h12345678;
      n_cmp++;
      if (got !== want) begin
         n_bad++; $display("FAIL wb_refresh_rest: got %h want %h", got, want);
      end
      d = rand_slot(); d.rs1 = 5'd0; d.rs2 = 5'd0;
      cycle(0, 0, 0, d, 0, 0, 0);
      cycle(0, 1, 0, rand_slot(), 1, 5'd0, 32'hCAFEF00D);
      n_cmp++;
      if (got !== d) begin
         n_bad++; $display("FAIL wb_refresh_x0: got %h want %h", got, d);
      end
   endtask

   task automatic test_flush_over_stall();
      slot_t d = rand_slot();
      logic [31:0] b0, s0;
      d.valid = 1'b1; d.reg_write = 1'b1; d.mem_read = 1'b1; d.mem_write = 1'b1;
      cycle(1, 0, 0, d, 0, 0, 0);
      cycle(0, 0, 0, d, 0, 0, 0);
      b0 = mdl_bub; s0 = mdl_stl;
      cycle(0, 1, 1, rand_slot(), 1, d.rs1, $urandom);
      n_cmp++;
      if (got !== slot_t'(0)) begin
         n_bad++; $display("FAIL flush_over_stall: got %h want 0", got);
      end
      n_cmp++;
      if (bubble_cnt !== (PERF ? b0 + 32'd1 : 32'd0) || stall_cnt !== (PERF ? s0 : 32'd0)) begin
         n_bad++; $display("FAIL flush_cnt: got %h/%h want %h/%h", bubble_cnt, stall_cnt,
                           PERF ? b0 + 32'd1 : 32'd0, PERF ? s0 : 32'd0);
      end
   endtask

   task automatic test_counter_wrap();
`ifdef ID_EX_PERF_CNT_EN
      @(negedge clk);
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt;
      mdl_stl = 32'hFFFF_FFFF;
`endif
      cycle(0, 1, 0, rand_slot(), 0, 0, 0);
      n_cmp++;
      if (stall_cnt !== 32'd0) begin
         n_bad++; $display("FAIL stall_wrap: got %h want 0", stall_cnt);
      end
      n_cmp++;
      if (bubble_cnt !== (PERF ? mdl_bub : 32'd0)) begin
         n_bad++; $display("FAIL wrap_bubble: got %h want %h", bubble_cnt, PERF ? mdl_bub : 32'd0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic r, s, f, w;
         logic [4:0] wr;
         r  = ($urandom_range(0, 99) < 3);
         s  = ($urandom_range(0, 99) < 35);
         f  = ($urandom_range(0, 99) < 10);
         w  = 1'($urandom);
         wr = $urandom_range(0, 1) != 0 ? ($urandom_range(0, 1) != 0 ? mdl.rs1 : mdl.rs2)
                                       : 5'($urandom_range(0, 7));
         cycle(r, s, f, rand_slot(), w, wr, $urandom);
         n_cmp++;
         if (got !== mdl) begin
            n_bad++; $display("FAIL random_slot[%0d]: got %h want %h", i, got, mdl);
         end
         n_cmp++;
         if (bubble_cnt !== (PERF ? mdl_bub : 32'd0) || stall_cnt !== (PERF ? mdl_stl : 32'd0)) begin
            n_bad++; $display("FAIL random_cnt[%0d]: got %h/%h want %h/%h", i, bubble_cnt,
                              stall_cnt, PERF ? mdl_bub : 32'd0, PERF ? mdl_stl : 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; drv = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      mdl = '0; mdl_bub = '0; mdl_stl = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_pass_through();
      test_stall_hold();
      test_wb_refresh();
      test_flush_over_stall();
      test_counter_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage pipeline, directly upstream of the EX operand muxes.
- Captures decoded operands, register addresses and control bits from ID each cycle.
- Supports stall (hold), flush (bubble insert) and a writeback refresh of held operands during stall.
- ex_read_data_1/ex_read_data_2 feed the EX ALU source muxes. ex_rs1/ex_rs2/ex_rd feed the forwarding unit.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register address width
- ALU_OP_W, 4, ALU operation code width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous reset, active-high
- stall  input  1  hold all EX-stage contents
- flush  input  1  replace EX-stage contents with a bubble
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  instruction PC
- id_read_data_1  input  XLEN  register file port 1 data
- id_read_data_2  input  XLEN  register file port 2 data
- id_imm  input  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  register addresses
- id_alu_op  input  ALU_OP_W  ALU operation
- id_alu_src  input  1  select immediate as ALU operand 2
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  input  1 each  control bits
- wb_reg_write  input  1  WB stage writes the register file this cycle
- wb_rd  input  REG_ADDR_W  WB destination register
- wb_data  input  XLEN  WB write data (same value as Write_data at the EX mux)
- ex_valid, ex_pc, ex_read_data_1, ex_read_data_2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  output  widths as the matching id_* ports  registered EX-stage copies
- bubble_cnt  output  32  bubbles inserted (see Optional Feature)
- stall_cnt  output  32  stall cycles (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - All ex_* outputs = 0, so ex_valid = 0 and every control bit = 0.
  - Both counters = 0.
  - rst has priority over flush and stall, and takes effect even in the middle of a stall.
- Priority per edge: rst > flush > stall > normal load.
- Normal load (no rst, flush or stall): every ex_* output = its id_* input on the next edge. Latency 1 cycle.
- Flush:
  - ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_alu_src = 0.
  - ex_alu_op = 0, ex_rs1 = ex_rs2 = ex_rd = 0.
  - ex_pc, ex_imm and both data fields = 0.
  - Flush asserted together with stall produces a bubble; flush wins.
- Stall:
  - All ex_* fields hold their values, with one exception (WB refresh).
  - WB refresh: while stalled, if wb_reg_write = 1, wb_rd != 0 and wb_rd == ex_rs1, then ex_read_data_1 <= wb_data. Same rule for ex_read_data_2 against ex_rs2.
  - Both operands update in the same cycle when ex_rs1 == ex_rs2.
  - Register x0 is never refreshed.
  - Purpose: the held instruction must not keep a stale register-file value after its producer retires.
- No refresh on a normal load. Same-cycle write-through is the register file's job.
- id_valid = 0 on a normal load: fields are captured as presented. ex_valid = 0 marks the slot invalid. Downstream qualifies writes with ex_valid.
- No combinational path from inputs to ex_* outputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on every edge where flush = 1 and rst = 0.
  - stall_cnt increments by 1 on every edge where stall = 1, flush = 0 and rst = 0.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on rst.
- Undefined: bubble_cnt and stall_cnt are constant 0 and no counter flops are synthesised.

Test Plan:
- Reset: assert rst for 2 cycles with all id_* = 1s -> every ex_* output = 0, ex_valid = 0. Release -> next edge captures id_*.
- Pass-through: id_pc = 0x100, id_read_data_1 = 0xDEADBEEF, id_rd = 7, id_reg_write = 1, id_valid = 1 -> one edge later ex_pc = 0x100, ex_read_data_1 = 0xDEADBEEF, ex_rd = 7, ex_reg_write = 1, ex_valid = 1.
- Stall hold: load ex_rs1 = 3, then stall for 3 cycles with changing id_* and wb_reg_write = 0 -> all ex_* unchanged for 3 cycles. Stall released -> new id_* captured on the next edge.
- WB refresh: ex_rs1 = ex_rs2 = 5, stall = 1, wb_reg_write = 1, wb_rd = 5, wb_data = 0x12345678 -> ex_read_data_1 = ex_read_data_2 = 0x12345678. Repeat with wb_rd = 0 and ex_rs1 = 0 -> no change.
- Flush over stall: stall = 1 and flush = 1 in the same cycle with valid contents held -> ex_valid = 0 and all control bits = 0. With ID_EX_PERF_CNT_EN: bubble_cnt = 1, stall_cnt unchanged.
- Counter wrap (ID_EX_PERF_CNT_EN): force stall_cnt to 0xFFFFFFFF, then one stall cycle -> stall_cnt = 0. Without the macro: both counters read 0 throughout.
